// File: rtl/atx_uart_pkg.sv
// Shared types and helpers for the atx_uart transmitter.
// State encoding, parity modes, divisor and parity math.
package atx_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clock cycles per bit, rounded to nearest.
  function automatic int divisor(
    input int clk_hz,
    input int baud
  );
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Parity bit for an already-masked data word.
  // Odd: make the total ones count odd.
  // Even: XOR of the data bits.
  function automatic logic frame_parity(
    input logic [7:0] d,
    input int         mode
  );
    logic p;
    p = ^d;
    if (mode == PARITY_ODD) begin
      return ~p;
    end else if (mode == PARITY_EVEN) begin
      return p;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/atx_uart_tx_baud.sv
// Bit-period timer for atx_uart_tx.
// Ports: clk, rst (async high), clear (sync), run (enable),
//        tick (one cycle on the terminal count).
module atx_baud_tick #(
  parameter int DIVISOR = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] count;

  assign tick = run & (count == LAST);

  // Clear wins over run so each frame starts at phase zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/atx_uart_tx.sv
// Async serial transmitter driven by the CPU atx_data/atx_load registers.
// Ports: clk, reset (async high), atx_data[7:0], atx_load (edge = send),
//        atx_busy (frame in progress), atx_txd (serial line, idles high).
module atx_uart_tx
  import atx_uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] atx_data,
  input  logic       atx_load,
  output logic       atx_busy,
  output logic       atx_txd
);

  localparam int DIVISOR = divisor(CLK_HZ, BAUD);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  if (DIVISOR < 2) begin : g_bad_divisor
    $error("atx_uart_tx: DIVISOR must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("atx_uart_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("atx_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("atx_uart_tx: PARITY must be 0, 1 or 2");
  end

  state_t     state;
  logic       load_q;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       par_q;
  logic       tick;
  logic       request;
  logic [7:0] data_m;

  assign data_m = 8'(atx_data[DATA_BITS-1:0]);

  // Edges outside IDLE are dropped, never queued.
  assign request = atx_load & ~load_q & (state == ST_IDLE);

  atx_baud_tick #(
    .DIVISOR(DIVISOR)
  ) u_baud (
    .clk  (clk),
    .rst  (reset),
    .clear(request),
    .run  (state != ST_IDLE),
    .tick (tick)
  );

  // load_q resets high so a load held through reset is not an edge.
  // bit_idx counts data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q   <= 1'b1;
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      par_q    <= 1'b0;
      atx_busy <= 1'b0;
      atx_txd  <= 1'b1;
    end else begin
      load_q <= atx_load;
      unique case (state)
        ST_IDLE: begin
          if (request) begin
            shreg    <= data_m;
            par_q    <= frame_parity(data_m, PARITY);
            bit_idx  <= '0;
            state    <= ST_START;
            atx_busy <= 1'b1;
            atx_txd  <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            atx_txd <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              if (PARITY != PARITY_NONE) begin
                state   <= ST_PARITY;
                atx_txd <= par_q;
              end else begin
                state   <= ST_STOP;
                atx_txd <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              atx_txd <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state   <= ST_STOP;
            atx_txd <= 1'b1;
            bit_idx <= '0;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              state    <= ST_IDLE;
              atx_busy <= 1'b0;
              bit_idx  <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          atx_busy <= 1'b0;
          atx_txd  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atx_uart_tx.sv
// Directed bench for atx_uart_tx at 1 MHz / 100 kbaud (10 clk per bit).
// Three instances: 8N1, 8E2 and 8O2; expected bytes go through a queue.
`timescale 1ns/1ps
module tb_atx_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic [2:0] load;
  logic [2:0] busy;
  logic [2:0] txd;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] q[$];

  always #5 clk = ~clk;

  atx_uart_tx #(
    .CLK_HZ(1_000_000), .BAUD(100_000),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .reset(rst), .atx_data(data),
    .atx_load(load[0]), .atx_busy(busy[0]), .atx_txd(txd[0])
  );

  atx_uart_tx #(
    .CLK_HZ(1_000_000), .BAUD(100_000),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
  ) dut1 (
    .clk(clk), .reset(rst), .atx_data(data),
    .atx_load(load[1]), .atx_busy(busy[1]), .atx_txd(txd[1])
  );

  atx_uart_tx #(
    .CLK_HZ(1_000_000), .BAUD(100_000),
    .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)
  ) dut2 (
    .clk(clk), .reset(rst), .atx_data(data),
    .atx_load(load[2]), .atx_busy(busy[2]), .atx_txd(txd[2])
  );

  function automatic int par_of(input int s);
    return (s == 1) ? 2 : ((s == 2) ? 1 : 0);
  endfunction

  function automatic int stp_of(input int s);
    return (s == 0) ? 1 : 2;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input int s, input logic val, input int limit);
    int n;
    n = 0;
    while (busy[s] !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_busy", 32'(busy[s]), 32'(val));
  endtask

  // Called at the negedge where load was raised; checks every cycle
  // of the frame against the byte at the head of the queue.
  task automatic rx_frame(input int s);
    int         hp;
    int         flen;
    int         slot;
    logic [7:0] e;
    logic [7:0] rx;
    logic       pe;
    logic       el;
    hp   = (par_of(s) != 0) ? 1 : 0;
    flen = (9 + hp + stp_of(s)) * 10;
    chk("sb_size", q.size(), 1);
    if (q.size() == 0) return;
    e  = q[0];
    pe = (par_of(s) == 2) ? ^e : ~^e;
    rx = '0;
    for (int k = 1; k <= flen; k++) begin
      @(negedge clk);
      slot = (k - 1) / 10;
      if (slot == 0) el = 1'b0;
      else if (slot <= 8) el = e[slot-1];
      else if (hp == 1 && slot == 9) el = pe;
      else el = 1'b1;
      chk("txd", 32'(txd[s]), 32'(el));
      chk("busy", 32'(busy[s]), 1);
      if ((k - 1) % 10 == 4) begin
        if (slot >= 1 && slot <= 8) rx[slot-1] = txd[s];
        if (hp == 1 && slot == 9) chk("parity", 32'(txd[s]), 32'(pe));
      end
    end
    @(negedge clk);
    chk("busy_end", 32'(busy[s]), 0);
    chk("idle_line", 32'(txd[s]), 1);
    e = q.pop_front();
    chk("rx_byte", 32'(rx), 32'(e));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    string msg;
    msg  = "AB\r\n";
    rst  = 1'b1;
    data = 8'h00;
    load = 3'b000;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk("rst_busy", 32'(busy[s]), 0);
      chk("rst_txd", 32'(txd[s]), 1);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single send; data changes after acceptance must not matter.
    data    = 8'h55;
    load[0] = 1'b1;
    q.push_back(8'h55);
    fork
      rx_frame(0);
      begin
        @(negedge clk);
        data = 8'hAA;
      end
    join

    // Load still held high: no retrigger.
    repeat (200) begin
      @(negedge clk);
      chk("held_no_send", 32'(busy[0]), 0);
    end
    load[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Edge while busy is discarded.
    data    = 8'hC3;
    load[0] = 1'b1;
    q.push_back(8'hC3);
    fork
      rx_frame(0);
      begin
        repeat (35) @(negedge clk);
        load[0] = 1'b0;
        repeat (10) @(negedge clk);
        load[0] = 1'b1;
        repeat (40) @(negedge clk);
        load[0] = 1'b0;
      end
    join
    repeat (5) begin
      @(negedge clk);
      chk("no_queued_edge", 32'(busy[0]), 0);
    end

    // Even parity, two stop bits, then odd parity.
    data    = 8'h41;
    load[1] = 1'b1;
    q.push_back(8'h41);
    rx_frame(1);
    load[1] = 1'b0;
    load[2] = 1'b1;
    q.push_back(8'h41);
    rx_frame(2);
    load[2] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-frame with load held high across it.
    data    = 8'h96;
    load[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("pre_reset_busy", 32'(busy[0]), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_txd", 32'(txd[0]), 1);
    chk("async_rst_busy", 32'(busy[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      chk("post_rst_no_send", 32'(busy[0]), 0);
    end
    load[0] = 1'b0;
    repeat (2) @(negedge clk);
    data    = 8'h3C;
    load[0] = 1'b1;
    q.push_back(8'h3C);
    rx_frame(0);
    load[0] = 1'b0;
    repeat (3) @(negedge clk);

    // CPU putchar loop, frames back-to-back.
    for (int i = 0; i < msg.len(); i++) begin
      wait_busy(0, 1'b0, 200);
      data    = msg[i];
      load[0] = 1'b1;
      q.push_back(msg[i]);
      fork
        rx_frame(0);
        begin
          wait_busy(0, 1'b1, 5);
          load[0] = 1'b0;
        end
      join
    end
    chk("sb_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
